// File: rtl/ctrl_fsm.sv
// Purpose : multi-cycle control sequencer; steps one opcode through DECODE/EXEC/MEM/WB phases.
// Latency : ALU/move retire 3 cycles after accept, branch 2, load/store wait on mem_ready, illegal drops after DECODE.
// Backpress: instr_ready is high only in FETCH; MEM holds until mem_ready, so one instruction is in flight at a time.
//
// Optional feature macro: CTRL_PERF_CNT_EN (saturating retire/stall counters; tied to 0 when undefined).
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   instr, instr_valid, instr_ready opcode handshake from fetch
//   mem_ready, mem_req              data memory request/complete
//   RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, MoveCtrl, ALUOp, pc_en  datapath controls
//   illegal                         one-cycle pulse on an unknown opcode
//   instr_cnt, stall_cnt            retired instructions / memory stall cycles
module ctrl_fsm #(
    parameter int MCODEBITS = 3,
    parameter int OPWIDTH   = 3,
    parameter int CNTW      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 RegDst,
    output logic                 Branch,
    output logic                 MemtoReg,
    output logic                 MemWrite,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic                 MoveCtrl,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic                 pc_en,
    output logic                 illegal,
    output logic [CNTW-1:0]      instr_cnt,
    output logic [CNTW-1:0]      stall_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [MCODEBITS-1:0]   r_op;

    logic                   w_op_hi;
    logic [2:0]             w_op_lo;
    logic                   w_is_alu;
    logic                   w_is_load;
    logic                   w_is_store;
    logic                   w_is_move;
    logic                   w_is_branch;
    logic                   w_is_illegal;
    logic [OPWIDTH-1:0]     w_alu_sel;

    // Any set bit above the 3-bit opcode map makes the opcode illegal.
    if (MCODEBITS > 3) begin : g_op_hi
        assign w_op_hi = |r_op[MCODEBITS-1:3];
    end else begin : g_no_op_hi
        assign w_op_hi = 1'b0;
    end

    assign w_op_lo      = r_op[2:0];
    assign w_is_alu     = !w_op_hi && (w_op_lo < 3'd3);
    assign w_is_load    = !w_op_hi && (w_op_lo == 3'd3);
    assign w_is_store   = !w_op_hi && (w_op_lo == 3'd4);
    assign w_is_move    = !w_op_hi && (w_op_lo == 3'd5);
    assign w_is_branch  = !w_op_hi && (w_op_lo == 3'd7);
    assign w_is_illegal = w_op_hi || (w_op_lo == 3'd6);

    // ALU ops use their own code; everything else leaves the ALU at all-ones.
    assign w_alu_sel = w_is_alu ? OPWIDTH'(w_op_lo[1:0]) : {OPWIDTH{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && instr_valid) begin
                r_op <= instr;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        RegDst      = 1'b0;
        Branch      = 1'b0;
        MemtoReg    = 1'b0;
        MemWrite    = 1'b0;
        ALUSrc      = 1'b0;
        RegWrite    = 1'b0;
        MoveCtrl    = 1'b0;
        ALUOp       = {OPWIDTH{1'b1}};
        pc_en       = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_illegal) begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end else begin
                    w_next  = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUOp = w_alu_sel;
                if (w_is_branch) begin
                    Branch = 1'b1;
                    pc_en  = 1'b1;
                    w_next = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                MemWrite = w_is_store;
                if (mem_ready) begin
                    // A store retires on the completing memory cycle; a load still needs writeback.
                    pc_en  = w_is_store;
                    w_next = w_is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = w_is_load;
                MoveCtrl = w_is_move;
                ALUOp    = w_alu_sel;
                pc_en    = 1'b1;
                w_next   = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNTW-1:0] r_instr_cnt;
    logic [CNTW-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (pc_en && (r_instr_cnt != {CNTW{1'b1}})) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
            if ((r_state == S_MEM) && !mem_ready && (r_stall_cnt != {CNTW{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign instr_cnt = r_instr_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Randomised bench for ctrl_fsm: each accepted opcode is expanded into its expected
// per-cycle control trace from the opcode class and memory stall count, and compared
// against a default instance and a CNTW=4 instance sharing the same inputs.
module tb_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] instr;
    logic       instr_valid;
    logic       mem_ready;

    always #5 clk = ~clk;

    logic        d_instr_ready, d_mem_req, d_RegDst, d_Branch, d_MemtoReg, d_MemWrite;
    logic        d_ALUSrc, d_RegWrite, d_MoveCtrl, d_pc_en, d_illegal;
    logic [2:0]  d_ALUOp;
    logic [15:0] d_instr_cnt, d_stall_cnt;

    logic        s_instr_ready, s_mem_req, s_RegDst, s_Branch, s_MemtoReg, s_MemWrite;
    logic        s_ALUSrc, s_RegWrite, s_MoveCtrl, s_pc_en, s_illegal;
    logic [2:0]  s_ALUOp;
    logic [3:0]  s_instr_cnt, s_stall_cnt;

    ctrl_fsm u_dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(d_instr_ready), .mem_ready(mem_ready), .mem_req(d_mem_req),
        .RegDst(d_RegDst), .Branch(d_Branch), .MemtoReg(d_MemtoReg), .MemWrite(d_MemWrite),
        .ALUSrc(d_ALUSrc), .RegWrite(d_RegWrite), .MoveCtrl(d_MoveCtrl), .ALUOp(d_ALUOp),
        .pc_en(d_pc_en), .illegal(d_illegal), .instr_cnt(d_instr_cnt), .stall_cnt(d_stall_cnt)
    );

    ctrl_fsm #(.CNTW(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(s_instr_ready), .mem_ready(mem_ready), .mem_req(s_mem_req),
        .RegDst(s_RegDst), .Branch(s_Branch), .MemtoReg(s_MemtoReg), .MemWrite(s_MemWrite),
        .ALUSrc(s_ALUSrc), .RegWrite(s_RegWrite), .MoveCtrl(s_MoveCtrl), .ALUOp(s_ALUOp),
        .pc_en(s_pc_en), .illegal(s_illegal), .instr_cnt(s_instr_cnt), .stall_cnt(s_stall_cnt)
    );

    typedef struct packed {
        logic       instr_ready;
        logic       mem_req;
        logic       RegDst;
        logic       Branch;
        logic       MemtoReg;
        logic       MemWrite;
        logic       ALUSrc;
        logic       RegWrite;
        logic       MoveCtrl;
        logic [2:0] ALUOp;
        logic       pc_en;
        logic       illegal;
    } outv_t;

    outv_t obs_d, obs_s;
    assign obs_d = {d_instr_ready, d_mem_req, d_RegDst, d_Branch, d_MemtoReg, d_MemWrite,
                    d_ALUSrc, d_RegWrite, d_MoveCtrl, d_ALUOp, d_pc_en, d_illegal};
    assign obs_s = {s_instr_ready, s_mem_req, s_RegDst, s_Branch, s_MemtoReg, s_MemWrite,
                    s_ALUSrc, s_RegWrite, s_MoveCtrl, s_ALUOp, s_pc_en, s_illegal};

    int n_chk = 0;
    int n_fail = 0;
    int ret_cnt = 0;   // instructions retired since last reset
    int stl_cnt = 0;   // MEM cycles spent waiting since last reset

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic outv_t quiet_v();
        outv_t v;
        v       = '0;
        v.ALUOp = 3'b111;
        return v;
    endfunction

    function automatic outv_t fetch_v();
        outv_t v;
        v             = quiet_v();
        v.instr_ready = 1'b1;
        return v;
    endfunction

    task automatic check_outs(input string tag, input outv_t e);
        chk({tag, "/dut"}, 32'(obs_d), 32'(e));
        chk({tag, "/sat"}, 32'(obs_s), 32'(e));
    endtask

    task automatic check_cnts(input string tag);
        int e16, e4s, e16s, e4;
`ifdef CTRL_PERF_CNT_EN
        e16  = (ret_cnt > 65535) ? 65535 : ret_cnt;
        e4   = (ret_cnt > 15)    ? 15    : ret_cnt;
        e16s = (stl_cnt > 65535) ? 65535 : stl_cnt;
        e4s  = (stl_cnt > 15)    ? 15    : stl_cnt;
`else
        e16 = 0; e4 = 0; e16s = 0; e4s = 0;
`endif
        chk({tag, "/instr_cnt"},     32'(d_instr_cnt), 32'(e16));
        chk({tag, "/stall_cnt"},     32'(d_stall_cnt), 32'(e16s));
        chk({tag, "/sat_instr_cnt"}, 32'(s_instr_cnt), 32'(e4));
        chk({tag, "/sat_stall_cnt"}, 32'(s_stall_cnt), 32'(e4s));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
            instr       = 3'($urandom);
            mem_ready   = 1'($urandom);
            @(negedge clk);
            check_outs("idle", fetch_v());
            check_cnts("idle");
        end
    endtask

    task automatic hold_reset(input int n);
        @(negedge clk);
        rst_n   = 1'b0;
        ret_cnt = 0;
        stl_cnt = 0;
        #1;
        check_outs("rst", fetch_v());
        check_cnts("rst");
        repeat (n) begin
            @(negedge clk);
            check_outs("rst_hold", fetch_v());
            check_cnts("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    // Offers op in a FETCH cycle and checks the whole expected trace.
    // abort_at >= 0 drops rst_n mid-cycle at that trace index.
    task automatic run_instr(input logic [2:0] op, input int nstall, input bit keep_valid,
                             input int abort_at);
        bit    is_alu, ld, st, mv, br, ill, in_mem;
        int    nph;
        outv_t e;
        is_alu = (op <= 3'd2);
        ld     = (op == 3'd3);
        st     = (op == 3'd4);
        mv     = (op == 3'd5);
        br     = (op == 3'd7);
        ill    = (op == 3'd6);
        if (ill)      nph = 1;
        else if (br)  nph = 2;
        else if (st)  nph = 2 + nstall + 1;
        else if (ld)  nph = 3 + nstall + 1;
        else          nph = 3;

        @(posedge clk); #1;
        instr       = op;
        instr_valid = 1'b1;
        mem_ready   = 1'($urandom);
        @(negedge clk);
        check_outs("handshake", fetch_v());
        check_cnts("handshake");

        for (int i = 0; i < nph; i++) begin
            @(posedge clk); #1;
            instr_valid = keep_valid ? 1'b1 : 1'($urandom);
            instr       = 3'($urandom);
            in_mem      = (ld || st) && (i >= 2) && (i <= 2 + nstall);
            mem_ready   = in_mem ? (i == 2 + nstall) : 1'($urandom);
            e = quiet_v();
            if (i == 0) begin
                e.illegal = ill;
            end else if (i == 1) begin
                e.ALUOp = is_alu ? op : 3'b111;
                e.Branch = br;
                e.pc_en  = br;
            end else if (in_mem) begin
                e.mem_req  = 1'b1;
                e.MemWrite = st;
                e.pc_en    = st && (i == 2 + nstall);
            end else begin
                e.RegWrite = 1'b1;
                e.MemtoReg = ld;
                e.MoveCtrl = mv;
                e.ALUOp    = is_alu ? op : 3'b111;
                e.pc_en    = 1'b1;
            end
            @(negedge clk);
            check_outs($sformatf("op%0d_ph%0d", op, i), e);
            if (e.pc_en) ret_cnt++;
            if (in_mem && !mem_ready) stl_cnt++;
            if (i == abort_at) begin
                #2;
                rst_n   = 1'b0;
                ret_cnt = 0;
                stl_cnt = 0;
                #1;
                check_outs("rst_async", fetch_v());
                check_cnts("rst_async");
                return;
            end
        end
    endtask

    initial begin
        logic [2:0] op;
        rst_n       = 1'b0;
        instr       = 3'd0;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_outs("reset", fetch_v());
            check_cnts("reset");
        end
        rst_n = 1'b1;

        // Directed walk through each opcode class.
        run_instr(3'd0, 0, 1'b0, -1);   // add
        run_instr(3'd3, 3, 1'b0, -1);   // load, three stall cycles
        idle(1);
        run_instr(3'd4, 0, 1'b0, -1);   // store, immediate completion
        run_instr(3'd7, 0, 1'b1, -1);   // branch
        run_instr(3'd6, 0, 1'b0, -1);   // illegal
        run_instr(3'd1, 0, 1'b0, -1);   // rotate-right
        run_instr(3'd2, 0, 1'b0, -1);   // NAND
        run_instr(3'd5, 0, 1'b0, -1);   // move
        idle(1);

        // Reset lands in the middle of a stalled load.
        run_instr(3'd3, 5, 1'b0, 3);
        repeat (2) begin
            @(negedge clk);
            check_outs("rst_mid_mem", fetch_v());
            check_cnts("rst_mid_mem");
        end
        rst_n = 1'b1;
        run_instr(3'd0, 0, 1'b0, -1);
        idle(1);

        // Random instruction mix with random gaps, stalls and valid patterns.
        for (int k = 0; k < 60; k++) begin
            op = 3'($urandom_range(0, 7));
            idle($urandom_range(0, 2));
            run_instr(op, $urandom_range(0, 4), 1'($urandom), -1);
        end
        idle(1);

        // Back-to-back moves with valid never dropping: CNTW=4 counter saturates.
        hold_reset(2);
        for (int k = 0; k < 20; k++) begin
            run_instr(3'd5, 0, 1'b1, -1);
        end
        idle(1);
`ifdef CTRL_PERF_CNT_EN
        chk("sat_final", 32'(s_instr_cnt), 32'd15);
        chk("full_final", 32'(d_instr_cnt), 32'd20);
`else
        chk("sat_final", 32'(s_instr_cnt), 32'd0);
        chk("full_final", 32'(d_instr_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multi-cycle control sequencer; the parametrised successor of the single-cycle combinational control decoder. It accepts one instruction opcode per valid/ready handshake, steps it through DECODE/EXEC/MEM/WB phases, and drives the datapath control lines one phase at a time. It waits on a memory ready handshake for loads and stores and flags illegal opcodes. It sits between the instruction fetch stage and the datapath (ALU, register file, data memory, PC).

## Interface
- MCODEBITS, 3: opcode width; must be ≥3.
- OPWIDTH, 3: ALUOp width; must be ≥2.
- CNTW, 16: width of the performance counters.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  MCODEBITS  opcode; sampled on handshake.
- instr_valid  in  1  fetch offers instr.
- instr_ready  out  1  sequencer accepts instr.
- mem_ready  in  1  data memory completes the current request.
- mem_req  out  1  memory request active.
- RegDst  out  1  always 0.
- Branch  out  1  branch compare/redirect.
- MemtoReg  out  1  writeback source is memory.
- MemWrite  out  1  store strobe.
- ALUSrc  out  1  always 0; reserved.
- RegWrite  out  1  register file write enable.
- MoveCtrl  out  1  writeback source is move path.
- ALUOp  out  OPWIDTH  ALU function.
- pc_en  out  1  instruction retires; PC advances.
- illegal  out  1  one-cycle illegal-opcode pulse.
- instr_cnt  out  CNTW  retired-instruction count.
- stall_cnt  out  CNTW  memory stall cycles.

## Operation
- Opcode map (zero-extended to MCODEBITS): 0 add (ALUOp=0), 1 rotate-right (ALUOp=1), 2 NAND (ALUOp=2), 3 load, 4 store, 5 move, 7 branch.
- Opcode 6 and every opcode >7 are illegal.
- Opcode register captures instr when instr_valid && instr_ready; it is held until the instruction retires.
- States:
  - FETCH: instr_ready=1; on handshake -> DECODE.
  - DECODE: illegal -> pulse illegal, -> FETCH (no pc_en); otherwise -> EXEC.
  - EXEC: ALUOp driven per opcode, all-ones for load/store/move/branch.
  - EXEC next state: ALU ops and move -> WB; load/store -> MEM; branch -> Branch=1 and pc_en=1, then -> FETCH.
  - MEM: mem_req=1; MemWrite=1 for store. Stays in MEM while mem_ready=0.
  - MEM exit on mem_ready=1: store -> pc_en=1, -> FETCH; load -> WB.
  - WB: RegWrite=1; MemtoReg=1 for load; MoveCtrl=1 for move; ALUOp held from EXEC; pc_en=1; -> FETCH.
- All control outputs are Moore decodes of state plus the opcode register, with no combinational path from instr.
- Default for any output not named active in a state: 0; ALUOp default is all-ones.
- A mem_ready outside MEM is ignored.

## Timing
- Reset (rst_n low, any state, mid-instruction included): state=FETCH immediately and opcode register cleared.
- Reset values: instr_ready=1, ALUOp all-ones, counters 0, every other output 0.
- ALU/move: handshake cycle T; DECODE T+1, EXEC T+2, WB T+3 (pc_en); next handshake possible at T+4.
- Branch: pc_en and Branch at T+2; next handshake at T+3.
- Load: MEM from T+3 for N+1 cycles, where N = zero-mem_ready cycles; then WB (pc_en).
- Store: pc_en on the MEM cycle with mem_ready=1.
- Illegal: illegal pulse at T+1; instr_ready again at T+2.
- instr_valid held high with no gaps: one instruction accepted per FETCH visit, never two.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - instr_cnt increments on every pc_en.
  - stall_cnt increments on every MEM cycle with mem_ready=0.
  - Both counters saturate at all-ones and clear only on reset.
- CTRL_PERF_CNT_EN undefined: counter logic is absent; instr_cnt and stall_cnt are tied to 0 and the ports are kept.

## Test plan
- Reset release, then add (0) offered at cycle 1 -> DECODE 2, EXEC 3 with ALUOp=0, WB 4 with RegWrite=1 and pc_en=1, instr_ready=1 at cycle 5.
- Load (3) with mem_ready low 3 cycles -> mem_req high 4 cycles, MemWrite=0, then WB with MemtoReg=1 and RegWrite=1. With the macro defined, stall_cnt=3 and instr_cnt=1.
- Store (4) with mem_ready immediately high -> single MEM cycle with MemWrite=1 and pc_en=1, RegWrite never asserted.
- Branch (7) -> Branch=1 and pc_en=1 for exactly one cycle at EXEC; next instruction accepted 3 cycles after handshake. Opcode 6 -> illegal pulse, no pc_en, instr_cnt unchanged.
- rst_n dropped mid-MEM of a load -> outputs at reset values asynchronously; no WB follows, and fresh operation starts from FETCH.
- CNTW=4 with macro defined and 20 back-to-back moves -> instr_cnt holds at 15, MoveCtrl=1 in each WB.
